// File: rtl/cache_structs_def.sv
`default_nettype none
// ============================================================================
// Package : cache_structs_def
// Purpose : Shared widths and types for the cache / memory write-buffer path.
//           Block geometry, buffer entry layout and write-buffer FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package cache_structs_def;

    localparam int BLK_ADDR_WIDTH = 10;
    localparam int BLOCK_WORDS    = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int BLOCK_BITS     = BLOCK_WORDS * DATA_WIDTH;

    // One posted write-back held in the buffer.
    typedef struct packed {
        logic                      valid;
        logic [BLK_ADDR_WIDTH-1:0] addr;
        logic [BLOCK_BITS-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_cam_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_cam_fifo
// Purpose : Write-buffer storage. Circular FIFO of {valid, addr, data} entries
//           with an associative lookup across all valid entries.
//           - read lookup  : youngest valid entry whose address matches
//           - write lookup : same, but optionally skipping the head entry
//                            while it is being issued to memory
//           A write that matches overwrites that entry's data in place;
//           otherwise it is appended at the tail.
// Ports   : clk_i, rst_ni        clock / async active-low reset
//           addr_i, data_i       request address and write payload
//           wr_i                 accepted write (coalesce or enqueue)
//           excl_head_i          head is in flight, exclude it from coalesce
//           pop_i                retire the head entry
//           rd_hit_o/rd_data_o   read lookup result
//           wr_match_o           write lookup result (coalesce possible)
//           head_addr_o/head_data_o  head entry (data includes same-cycle
//                                coalesce so a latched copy is never stale)
//           count_o, full_o      occupancy
// Revision: 1.0 - initial release
// ============================================================================
module wb_cam_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     wr_i,
    input  logic                     excl_head_i,
    input  logic                     pop_i,
    output logic                     rd_hit_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     wr_match_o,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic              rd_hit;
    logic              wr_hit;
    logic              enq;
    logic              coal;

    // Walk from head (oldest) to tail so later matches override earlier ones,
    // leaving the youngest match selected.
    always_comb begin
        scan_idx = '0;
        rd_idx   = '0;
        wr_idx   = '0;
        rd_hit   = 1'b0;
        wr_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == addr_i)) begin
                rd_hit = 1'b1;
                rd_idx = scan_idx;
                if (!(excl_head_i && (i == 0))) begin
                    wr_hit = 1'b1;
                    wr_idx = scan_idx;
                end
            end
        end
    end

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign rd_hit_o   = rd_hit;
    assign rd_data_o  = data_q[rd_idx];
    assign wr_match_o = wr_hit;
    assign coal       = wr_i && wr_hit;
    assign enq        = wr_i && !wr_hit && !full_o;

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = (coal && (wr_idx == rd_ptr_q)) ? data_i : data_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pop and enqueue never target the same slot: enqueue needs a
            // non-full FIFO and pop a non-empty one, so the pointers differ.
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            unique case ({enq, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= addr_i;
            data_q[wr_ptr_q] <= data_i;
        end
        if (coal) begin
            data_q[wr_idx] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module  : mem_write_buffer
// Purpose : Posted-write buffer between the cache request path and mem_ctrl.
//           Write-backs are absorbed into a small coalescing FIFO; read misses
//           bypass queued writes; reads that hit a queued block are answered
//           from the buffer. Queued writes drain while no read is pending.
//           A flush handshake reports when memory is coherent.
// Ports   : clk, rst (async, active-low)
//           c_req_*   cache request (valid/ready), c_res_* read response pulse
//           flush_req / flush_done   drain handshake
//           m_req_*   memory request (valid/ready), m_res_* memory read data
// Revision: 1.0 - initial release
// ============================================================================
module mem_write_buffer #(
    parameter int DEPTH          = 4,
    parameter int BLK_ADDR_WIDTH = cache_structs_def::BLK_ADDR_WIDTH,
    parameter int BLOCK_BITS     = cache_structs_def::BLOCK_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      c_req_valid,
    input  logic                      c_req_rw,
    input  logic [BLK_ADDR_WIDTH-1:0] c_req_addr,
    input  logic [BLOCK_BITS-1:0]     c_req_data,
    output logic                      c_req_ready,
    output logic                      c_res_valid,
    output logic [BLOCK_BITS-1:0]     c_res_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      m_req_valid,
    output logic                      m_req_rw,
    output logic [BLK_ADDR_WIDTH-1:0] m_req_addr,
    output logic [BLOCK_BITS-1:0]     m_req_data,
    input  logic                      m_req_ready,
    input  logic                      m_res_valid,
    input  logic [BLOCK_BITS-1:0]     m_res_data
);

    import cache_structs_def::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t                 state_q, state_d;
    logic                      m_req_valid_q, m_req_valid_d;
    logic                      m_req_rw_q, m_req_rw_d;
    logic [BLK_ADDR_WIDTH-1:0] m_req_addr_q, m_req_addr_d;
    logic [BLOCK_BITS-1:0]     m_req_data_q, m_req_data_d;
    logic                      c_res_valid_q, c_res_valid_d;
    logic [BLOCK_BITS-1:0]     c_res_data_q, c_res_data_d;
    logic                      flush_done_q, flush_done_d;

    logic                      fifo_rd_hit;
    logic [BLOCK_BITS-1:0]     fifo_rd_data;
    logic                      fifo_wr_match;
    logic [BLK_ADDR_WIDTH-1:0] fifo_head_addr;
    logic [BLOCK_BITS-1:0]     fifo_head_data;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_pop;

    logic                      wr_fire;
    logic                      rd_hit_fire;
    logic                      rd_miss_fire;

    wb_cam_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (BLK_ADDR_WIDTH),
        .DATA_W (BLOCK_BITS)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .addr_i      (c_req_addr),
        .data_i      (c_req_data),
        .wr_i        (wr_fire),
        .excl_head_i (state_q == WR_ISSUE),
        .pop_i       (fifo_pop),
        .rd_hit_o    (fifo_rd_hit),
        .rd_data_o   (fifo_rd_data),
        .wr_match_o  (fifo_wr_match),
        .head_addr_o (fifo_head_addr),
        .head_data_o (fifo_head_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full)
    );

    // Read hits are refused only in the one cycle where a memory response
    // also lands, so the response register has a single writer per cycle.
    always_comb begin
        c_req_ready = 1'b0;
        if (c_req_rw) begin
            c_req_ready = fifo_wr_match || !fifo_full;
        end else if (fifo_rd_hit) begin
            c_req_ready = !((state_q == RD_WAIT) && m_res_valid);
        end else begin
            c_req_ready = (state_q == IDLE);
        end
    end

    assign wr_fire      = c_req_valid && c_req_ready &&  c_req_rw;
    assign rd_hit_fire  = c_req_valid && c_req_ready && !c_req_rw &&  fifo_rd_hit;
    assign rd_miss_fire = c_req_valid && c_req_ready && !c_req_rw && !fifo_rd_hit;

    always_comb begin
        state_d       = state_q;
        m_req_valid_d = m_req_valid_q;
        m_req_rw_d    = m_req_rw_q;
        m_req_addr_d  = m_req_addr_q;
        m_req_data_d  = m_req_data_q;
        c_res_valid_d = 1'b0;
        c_res_data_d  = c_res_data_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd_miss_fire) begin
                    state_d       = RD_ISSUE;
                    m_req_valid_d = 1'b1;
                    m_req_rw_d    = 1'b0;
                    m_req_addr_d  = c_req_addr;
                    m_req_data_d  = '0;
                end else if (fifo_count != '0) begin
                    state_d       = WR_ISSUE;
                    m_req_valid_d = 1'b1;
                    m_req_rw_d    = 1'b1;
                    m_req_addr_d  = fifo_head_addr;
                    m_req_data_d  = fifo_head_data;
                end
            end
            RD_ISSUE: begin
                if (m_req_ready) begin
                    state_d       = RD_WAIT;
                    m_req_valid_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (m_res_valid) begin
                    state_d       = IDLE;
                    c_res_valid_d = 1'b1;
                    c_res_data_d  = m_res_data;
                end
            end
            WR_ISSUE: begin
                if (m_req_ready) begin
                    state_d       = IDLE;
                    m_req_valid_d = 1'b0;
                    fifo_pop      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_hit_fire) begin
            c_res_valid_d = 1'b1;
            c_res_data_d  = fifo_rd_data;
        end
    end

    // Coherent means nothing queued, nothing in flight and nothing about to be.
    assign flush_done_d = flush_req && (fifo_count == '0) && !wr_fire &&
                          (state_q == IDLE) && !rd_miss_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            m_req_valid_q <= 1'b0;
            m_req_rw_q    <= 1'b0;
            m_req_addr_q  <= '0;
            m_req_data_q  <= '0;
            c_res_valid_q <= 1'b0;
            c_res_data_q  <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_req_valid_q <= m_req_valid_d;
            m_req_rw_q    <= m_req_rw_d;
            m_req_addr_q  <= m_req_addr_d;
            m_req_data_q  <= m_req_data_d;
            c_res_valid_q <= c_res_valid_d;
            c_res_data_q  <= c_res_data_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign m_req_valid = m_req_valid_q;
    assign m_req_rw    = m_req_rw_q;
    assign m_req_addr  = m_req_addr_q;
    assign m_req_data  = m_req_data_q;
    assign c_res_valid = c_res_valid_q;
    assign c_res_data  = c_res_data_q;
    assign flush_done  = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mem_write_buffer
// Purpose : Directed self-checking bench for mem_write_buffer with a simple
//           memory model (controllable ready, fixed-latency read responses).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_write_buffer;

    import cache_structs_def::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         c_req_valid;
    logic         c_req_rw;
    logic [9:0]   c_req_addr;
    logic [127:0] c_req_data;
    logic         c_req_ready;
    logic         c_res_valid;
    logic [127:0] c_res_data;
    logic         flush_req;
    logic         flush_done;
    logic         m_req_valid;
    logic         m_req_rw;
    logic [9:0]   m_req_addr;
    logic [127:0] m_req_data;
    logic         m_req_ready;
    logic         m_res_valid;
    logic [127:0] m_res_data;

    always #5 clk = ~clk;

    mem_write_buffer #(
        .DEPTH          (4),
        .BLK_ADDR_WIDTH (10),
        .BLOCK_BITS     (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_req_valid (c_req_valid),
        .c_req_rw    (c_req_rw),
        .c_req_addr  (c_req_addr),
        .c_req_data  (c_req_data),
        .c_req_ready (c_req_ready),
        .c_res_valid (c_res_valid),
        .c_res_data  (c_res_data),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .m_req_valid (m_req_valid),
        .m_req_rw    (m_req_rw),
        .m_req_addr  (m_req_addr),
        .m_req_data  (m_req_data),
        .m_req_ready (m_req_ready),
        .m_res_valid (m_res_valid),
        .m_res_data  (m_res_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- memory model / monitors ----------------
    int           cyc = 0;
    logic [9:0]   wa_q [$];
    logic [127:0] wd_q [$];
    logic [10:0]  ord_q [$];
    int           rd_issued = 0;
    logic [9:0]   rd_addr = '0;
    int           resp_done = 0;
    int           resp_wait = 0;
    int           inj_done = 0;
    bit           resp_en = 1'b0;
    int           inj_req = 0;
    logic [127:0] res_q [$];
    int           res_cyc [$];
    int           mres_cyc [$];

    function automatic logic [127:0] rdata(input logic [9:0] a);
        return {4{16'hBEEF, 6'd0, a}};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_req_valid && m_req_ready) begin
            ord_q.push_back({m_req_rw, m_req_addr});
            if (m_req_rw) begin
                wa_q.push_back(m_req_addr);
                wd_q.push_back(m_req_data);
            end else begin
                rd_issued = rd_issued + 1;
                rd_addr   = m_req_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (c_res_valid) begin
            res_q.push_back(c_res_data);
            res_cyc.push_back(cyc);
        end
        if (m_res_valid) mres_cyc.push_back(cyc);
    end

    // Answers each read handshake three cycles later; can also inject a stray
    // response on request.
    initial begin
        m_res_valid = 1'b0;
        m_res_data  = '0;
        forever begin
            @(posedge clk); #1;
            m_res_valid = 1'b0;
            if (inj_req > inj_done) begin
                inj_done    = inj_done + 1;
                m_res_valid = 1'b1;
                m_res_data  = {4{32'hDEAD_0BAD}};
            end else if (resp_en && (rd_issued > resp_done)) begin
                if (resp_wait < 2) begin
                    resp_wait = resp_wait + 1;
                end else begin
                    resp_wait   = 0;
                    m_res_valid = 1'b1;
                    m_res_data  = rdata(rd_addr);
                    resp_done   = resp_done + 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a request for up to 'budget' edges; acc reports acceptance.
    task automatic req(input logic rw, input logic [9:0] a, input logic [127:0] d,
                       input int budget, output logic acc);
        acc         = 1'b0;
        c_req_valid = 1'b1;
        c_req_rw    = rw;
        c_req_addr  = a;
        c_req_data  = d;
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk); #3;
            acc = c_req_ready;
            @(posedge clk); #1;
        end
        c_req_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while ((wa_q.size() < target) && (n < 100)) begin
            tick(1);
            n++;
        end
        chk(tag, wa_q.size(), target);
    endtask

    // ---------------- directed sequence ----------------
    logic         acc;
    int           wb, rb, ob, rsb, mb, n;
    logic [127:0] d;

    initial begin
        rst         = 1'b0;
        c_req_valid = 1'b0;
        c_req_rw    = 1'b0;
        c_req_addr  = '0;
        c_req_data  = '0;
        flush_req   = 1'b0;
        m_req_ready = 1'b0;

        // Reset values
        tick(2);
        chk("rst_m_req_valid", m_req_valid, 0);
        chk("rst_m_req_rw",    m_req_rw,    0);
        chk("rst_m_req_addr",  m_req_addr,  0);
        chk("rst_m_req_data",  m_req_data,  0);
        chk("rst_c_res_valid", c_res_valid, 0);
        chk("rst_c_res_data",  c_res_data,  0);
        chk("rst_flush_done",  flush_done,  0);
        rst = 1'b1;
        tick(2);

        // 1: three writes held by memory, then drained in order
        wb = wa_q.size();
        req(1'b1, 10'h010, {4{32'hAAAA_0001}}, 4, acc); chk("t1_acc_010", acc, 1);
        req(1'b1, 10'h020, {4{32'hBBBB_0002}}, 4, acc); chk("t1_acc_020", acc, 1);
        req(1'b1, 10'h030, {4{32'hCCCC_0003}}, 4, acc); chk("t1_acc_030", acc, 1);
        chk("t1_count",     dut.u_fifo.count_q, 3);
        chk("t1_mreq_valid", m_req_valid, 1);
        chk("t1_mreq_rw",    m_req_rw,    1);
        chk("t1_mreq_addr",  m_req_addr,  10'h010);
        m_req_ready = 1'b1;
        wait_writes(wb + 3, "t1_drain");
        chk("t1_w0_addr", wa_q[wb],     10'h010);
        chk("t1_w0_data", wd_q[wb],     {4{32'hAAAA_0001}});
        chk("t1_w1_addr", wa_q[wb + 1], 10'h020);
        chk("t1_w1_data", wd_q[wb + 1], {4{32'hBBBB_0002}});
        chk("t1_w2_addr", wa_q[wb + 2], 10'h030);
        chk("t1_w2_data", wd_q[wb + 2], {4{32'hCCCC_0003}});
        tick(2);
        m_req_ready = 1'b0;

        // 2: fill, stall on new address, stall on in-flight head, coalesce
        wb = wa_q.size();
        for (int i = 0; i < 4; i++) begin
            d = {4{32'hE000_0000 | 32'(i)}};
            req(1'b1, 10'(16 * (i + 1)), d, 4, acc);
            chk($sformatf("t2_acc%0d", i), acc, 1);
        end
        req(1'b1, 10'h050, {4{32'h5555_5555}}, 3, acc); chk("t2_full_stall", acc, 0);
        req(1'b1, 10'h010, {4{32'h1111_1111}}, 3, acc); chk("t2_head_stall", acc, 0);
        req(1'b1, 10'h020, {4{32'hF00D_F00D}}, 2, acc); chk("t2_coalesce", acc, 1);
        chk("t2_count", dut.u_fifo.count_q, 4);
        m_req_ready = 1'b1;
        wait_writes(wb + 4, "t2_drain");
        chk("t2_w0", {wa_q[wb],     wd_q[wb][31:0]},     {10'h010, 32'hE000_0000});
        chk("t2_w1", {wa_q[wb + 1], wd_q[wb + 1][31:0]}, {10'h020, 32'hF00D_F00D});
        chk("t2_w2", {wa_q[wb + 2], wd_q[wb + 2][31:0]}, {10'h030, 32'hE000_0002});
        chk("t2_w3", {wa_q[wb + 3], wd_q[wb + 3][31:0]}, {10'h040, 32'hE000_0003});
        tick(2);
        m_req_ready = 1'b0;

        // 3: read hit served from the buffer
        wb = wa_q.size();
        rb = rd_issued;
        req(1'b1, 10'h040, {4{32'hDDDD_0004}}, 4, acc); chk("t3_wr_acc", acc, 1);
        req(1'b0, 10'h040, '0, 4, acc);                 chk("t3_rd_acc", acc, 1);
        chk("t3_res_valid", c_res_valid, 1);
        chk("t3_res_data",  c_res_data,  {4{32'hDDDD_0004}});
        tick(1);
        chk("t3_res_pulse", c_res_valid, 0);
        m_req_ready = 1'b1;
        wait_writes(wb + 1, "t3_drain");
        tick(2);
        chk("t3_no_mem_read", rd_issued, rb);

        // 4: read misses bypass queued writes
        resp_en = 1'b1;
        wb  = wa_q.size();
        ob  = ord_q.size();
        rsb = res_q.size();
        mb  = mres_cyc.size();
        req(1'b0, 10'h066, '0, 4, acc); chk("t4_rd066_acc", acc, 1);
        chk("t4_mreq_valid", m_req_valid, 1);
        chk("t4_mreq_rw",    m_req_rw,    0);
        chk("t4_mreq_addr",  m_req_addr,  10'h066);
        req(1'b1, 10'h0A0, {4{32'hA0A0_A0A0}}, 4, acc); chk("t4_wrA0_acc", acc, 1);
        req(1'b1, 10'h0B0, {4{32'hB0B0_B0B0}}, 4, acc); chk("t4_wrB0_acc", acc, 1);
        req(1'b0, 10'h077, '0, 20, acc);                chk("t4_rd077_acc", acc, 1);
        n = 0;
        while (((res_q.size() < rsb + 2) || (wa_q.size() < wb + 2)) && (n < 60)) begin
            tick(1);
            n++;
        end
        chk("t4_order0", ord_q[ob],     {1'b0, 10'h066});
        chk("t4_order1", ord_q[ob + 1], {1'b0, 10'h077});
        chk("t4_order2", ord_q[ob + 2], {1'b1, 10'h0A0});
        chk("t4_order3", ord_q[ob + 3], {1'b1, 10'h0B0});
        chk("t4_res066", res_q[rsb],     rdata(10'h066));
        chk("t4_res077", res_q[rsb + 1], rdata(10'h077));
        chk("t4_res_latency", res_cyc[rsb + 1], mres_cyc[mb + 1] + 1);
        tick(2);
        m_req_ready = 1'b0;

        // 5: flush handshake
        wb = wa_q.size();
        req(1'b1, 10'h0C0, {4{32'h0C0C_0C0C}}, 4, acc); chk("t5_acc0", acc, 1);
        req(1'b1, 10'h0D0, {4{32'h0D0D_0D0D}}, 4, acc); chk("t5_acc1", acc, 1);
        req(1'b1, 10'h0E0, {4{32'h0E0E_0E0E}}, 4, acc); chk("t5_acc2", acc, 1);
        flush_req = 1'b1;
        tick(3);
        chk("t5_done_low_busy", flush_done, 0);
        m_req_ready = 1'b1;
        n = 0;
        while ((flush_done !== 1'b1) && (n < 40)) begin
            tick(1);
            n++;
        end
        chk("t5_done_rise",   flush_done,  1);
        chk("t5_all_written", wa_q.size(), wb + 3);
        chk("t5_mem_idle",    m_req_valid, 0);
        flush_req = 1'b0;
        chk("t5_done_hold", flush_done, 1);
        tick(1);
        chk("t5_done_fall", flush_done, 0);

        // 6: reset during RD_WAIT with writes queued
        resp_en = 1'b0;
        req(1'b0, 10'h099, '0, 4, acc); chk("t6_rd_acc", acc, 1);
        tick(1);
        req(1'b1, 10'h0F0, {4{32'h0F0F_0F0F}}, 4, acc); chk("t6_wr0_acc", acc, 1);
        req(1'b1, 10'h0F8, {4{32'h0F8F_0F8F}}, 4, acc); chk("t6_wr1_acc", acc, 1);
        chk("t6_count_pre", dut.u_fifo.count_q, 2);
        chk("t6_state_pre", dut.state_q, RD_WAIT);
        rsb = res_q.size();
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_mvalid",   m_req_valid, 0);
        chk("t6_rst_count",    dut.u_fifo.count_q, 0);
        chk("t6_rst_resvalid", c_res_valid, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        inj_req = inj_req + 1;
        tick(4);
        chk("t6_late_res_ignored", res_q.size(), rsb);
        chk("t6_state_idle",       dut.state_q, IDLE);
        chk("t6_mvalid_idle",      m_req_valid, 0);

        // Asynchronous drop of an in-flight write request
        m_req_ready = 1'b0;
        req(1'b1, 10'h1F0, {4{32'h1F1F_1F1F}}, 4, acc); chk("t6_wr2_acc", acc, 1);
        tick(1);
        chk("t6_mvalid_up", m_req_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_async_drop", m_req_valid, 0);
        tick(1);
        rst = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer between the cache's memory request path and mem_ctrl.
- Absorbs dirty-block evictions (write-backs) into a small FIFO and lets read misses bypass queued writes.
- Forwards read data straight from the buffer when the requested block is still queued.
- Drains the FIFO to memory when no read is pending. Supports a flush handshake so the cache's flush completes only once memory is coherent.

Parameters:
- DEPTH, 4, number of buffered block writes (power of 2, ≥2).
- BLK_ADDR_WIDTH, 10, block address width (word address minus offset bits).
- BLOCK_BITS, 128, block payload width (BLOCK_WORDS*DATA_WIDTH from package).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req_valid  in  1  cache request valid; held until accepted.
- c_req_rw  in  1  1=write-back, 0=block read.
- c_req_addr  in  BLK_ADDR_WIDTH  block address.
- c_req_data  in  BLOCK_BITS  write-back payload.
- c_req_ready  out  1  request accepted this cycle when high with c_req_valid.
- c_res_valid  out  1  one-cycle pulse: read data valid.
- c_res_data  out  BLOCK_BITS  read data.
- flush_req  in  1  level; cache requests full drain.
- flush_done  out  1  level; FIFO empty and no memory op in flight while flush_req high.
- m_req_valid  out  1  memory request valid.
- m_req_rw  out  1  1=write, 0=read.
- m_req_addr  out  BLK_ADDR_WIDTH  memory block address.
- m_req_data  out  BLOCK_BITS  write payload.
- m_req_ready  in  1  mem_ctrl accepts request.
- m_res_valid  in  1  read data returned.
- m_res_data  in  BLOCK_BITS  read data.

Behaviour:
- Reset: FIFO count=0, pointers=0, FSM=IDLE. All registered outputs 0 (c_res_valid, c_res_data, m_req_valid, m_req_rw, m_req_addr, m_req_data, flush_done). Reset mid-operation discards queued writes and any outstanding read; m_req_valid falls asynchronously.
- FIFO entries: {valid, addr, data}. Address match compares c_req_addr against all valid entries.
- Write accept (c_req_ready=1, combinational):
  - if addr matches a queued entry → coalesce: overwrite that entry's data in place; count unchanged.
  - else if count<DEPTH → enqueue at tail.
  - Full with no match → ready=0.
  - Match against the entry currently being issued to memory (WR_ISSUE head) → not a coalesce. Enqueue as a new entry, or stall if full.
- Read accept:
  - FIFO hit (youngest matching entry): ready=1 in any state. c_res_valid pulses the next cycle with entry data; no memory access.
  - Miss: ready=1 only in IDLE; the FSM goes to RD_ISSUE. Otherwise ready=0.
- FSM:
  - IDLE: pending read miss → RD_ISSUE; else count>0 → WR_ISSUE (head entry); else stay.
  - RD_ISSUE: m_req_valid=1, rw=0, addr latched. On m_req_ready → RD_WAIT.
  - RD_WAIT: on m_res_valid, register m_res_data onto c_res_data, pulse c_res_valid next cycle → IDLE.
  - WR_ISSUE: m_req_valid=1, rw=1, head addr/data. On m_req_ready → pop head, → IDLE.
- m_req_* stable while m_req_valid && !m_req_ready.
- Read-miss latency: 1 cycle (accept→m_req_valid) + memory latency + 1 cycle (m_res_valid→c_res_valid).
- Simultaneous pop and enqueue in one cycle: count unchanged; both pointers advance.
- Pointer wrap: modulo DEPTH. Full/empty from a count register of width $clog2(DEPTH)+1.
- Flush: while flush_req=1, new writes are still accepted. flush_done=1 (registered) when count==0 and FSM==IDLE and no read pending; drops the cycle after flush_req falls.
- m_res_valid outside RD_WAIT is ignored.

Decomposition:
- Shared package cache_structs_def: BLK_ADDR_WIDTH, BLOCK_WORDS, DATA_WIDTH, BLOCK_BITS; typedef wb_entry_t {valid, addr, data}; typedef enum wb_state_t {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE}.
- One sub-module: wb_cam_fifo. Holds the FIFO storage, pointers, count, youngest-match search and coalescing write. The top level holds the FSM, flush logic and memory interface.

Test Plan:
- Three writes (0x010, 0x020, 0x030; data A/B/C), mem_ctrl ready=0 → count=3, all c_req_ready=1. Release ready → memory sees writes in order 0x010, 0x020, 0x030.
- Four writes then a fifth to new addr 0x050 with mem ready=0 → fifth stalls (c_req_ready=0). A fifth to 0x020 coalesces, accepted immediately, later written with new data.
- Queue write 0x040=D, then read 0x040 → c_res_valid the cycle after accept with data D, zero memory reads issued.
- Queue two writes, then read miss 0x077 → memory read for 0x077 issued before both writes. c_res_valid pulses one cycle after m_res_valid with that data.
- Queue three writes, assert flush_req → flush_done rises only after third write accepted by memory and FSM idle; falls one cycle after flush_req deasserts.
- Assert rst low during RD_WAIT with two writes queued → m_req_valid drops immediately, count=0, no c_res_valid. After release, a late m_res_valid is ignored.
